// File: rtl/relay_pkg.sv
// Shared types and constants for the 4PDT relay model.
package relay_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PULLING  = 2'd1,
        ENGAGED  = 2'd2,
        DROPPING = 2'd3
    } relay_state_e;

    localparam int RELAY_POLES    = 4;
    localparam int DEF_ACT_CYCLES = 3;
    localparam int DEF_REL_CYCLES = 2;

endpackage

// File: rtl/relay_4pdt_timer.sv
// 8-bit loadable down counter timing armature travel.
module relay_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic [7:0] value,
    output logic       zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 8'd0;
        end else if (load) begin
            value <= load_val;
        end else if (dec) begin
            value <= value - 8'd1;
        end
    end

    assign zero = (value == 8'd0);

endmodule

// File: rtl/relay_4pdt.sv
// Four-pole double-throw relay with break-before-make transit states.
// Optional engage counter enabled by RELAY_CONTACT_COUNT_EN.
module relay_4pdt
    import relay_pkg::*;
#(
    parameter int ACT_CYCLES = DEF_ACT_CYCLES,
    parameter int REL_CYCLES = DEF_REL_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        control,
    input  logic        in_0,
    input  logic        in_1,
    input  logic        in_2,
    input  logic        in_3,
    output logic        out_hi_0,
    output logic        out_hi_1,
    output logic        out_hi_2,
    output logic        out_hi_3,
    output logic        out_lo_0,
    output logic        out_lo_1,
    output logic        out_lo_2,
    output logic        out_lo_3,
    output logic        engaged,
    output logic        busy
`ifdef RELAY_CONTACT_COUNT_EN
    ,
    output logic [15:0] engage_count
`endif
);

    localparam logic [7:0] ACT_LD = 8'(ACT_CYCLES - 1);
    localparam logic [7:0] REL_LD = 8'(REL_CYCLES - 1);

    relay_state_e state_q, state_d;

    logic       tmr_load;
    logic [7:0] tmr_load_val;
    logic       tmr_dec;
    logic [7:0] tmr_value;
    logic       tmr_zero;
    logic       tmr_more;

    relay_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    assign tmr_more = |tmr_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RELEASED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_load_val = 8'd0;
        tmr_dec      = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (control) begin
                    state_d      = PULLING;
                    tmr_load     = 1'b1;
                    tmr_load_val = ACT_LD;
                end
            end
            PULLING: begin
                if (!control) begin
                    state_d      = DROPPING;
                    tmr_load     = 1'b1;
                    tmr_load_val = REL_LD;
                end else if (tmr_zero) begin
                    state_d = ENGAGED;
                end else begin
                    tmr_dec = tmr_more;
                end
            end
            ENGAGED: begin
                if (!control) begin
                    state_d      = DROPPING;
                    tmr_load     = 1'b1;
                    tmr_load_val = REL_LD;
                end
            end
            DROPPING: begin
                if (control) begin
                    state_d      = PULLING;
                    tmr_load     = 1'b1;
                    tmr_load_val = ACT_LD;
                end else if (tmr_zero) begin
                    state_d = RELEASED;
                end else begin
                    tmr_dec = tmr_more;
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    // Contact matrix: open throws are driven low, both open in transit.
    logic [RELAY_POLES-1:0] in_v;
    logic [RELAY_POLES-1:0] hi_v;
    logic [RELAY_POLES-1:0] lo_v;

    assign in_v = {in_3, in_2, in_1, in_0};

    always_comb begin
        hi_v = '0;
        lo_v = '0;
        unique case (state_q)
            RELEASED: lo_v = in_v;
            ENGAGED:  hi_v = in_v;
            default: ;
        endcase
    end

    assign {out_hi_3, out_hi_2, out_hi_1, out_hi_0} = hi_v;
    assign {out_lo_3, out_lo_2, out_lo_1, out_lo_0} = lo_v;

    assign engaged = (state_q == ENGAGED);
    assign busy    = (state_q == PULLING) || (state_q == DROPPING);

`ifdef RELAY_CONTACT_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'd0;
        end else if (state_q == PULLING && state_d == ENGAGED
                     && count_q != 16'hFFFF) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign engage_count = count_q;
`endif

endmodule

// File: tb/tb_relay_4pdt.sv
// Directed self-checking bench for relay_4pdt (default timing 3/2).
module tb_relay_4pdt;

    logic       clk;
    logic       rst_n;
    logic       control;
    logic [3:0] in_v;
    logic [3:0] hi;
    logic [3:0] lo;
    logic       engaged;
    logic       busy;
    logic       out_hi_0, out_hi_1, out_hi_2, out_hi_3;
    logic       out_lo_0, out_lo_1, out_lo_2, out_lo_3;
`ifdef RELAY_CONTACT_COUNT_EN
    logic [15:0] engage_count;
`endif

    int errors = 0;
    int checks = 0;

    relay_4pdt dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .control  (control),
        .in_0     (in_v[0]),
        .in_1     (in_v[1]),
        .in_2     (in_v[2]),
        .in_3     (in_v[3]),
        .out_hi_0 (out_hi_0),
        .out_hi_1 (out_hi_1),
        .out_hi_2 (out_hi_2),
        .out_hi_3 (out_hi_3),
        .out_lo_0 (out_lo_0),
        .out_lo_1 (out_lo_1),
        .out_lo_2 (out_lo_2),
        .out_lo_3 (out_lo_3),
        .engaged  (engaged),
        .busy     (busy)
`ifdef RELAY_CONTACT_COUNT_EN
        ,
        .engage_count (engage_count)
`endif
    );

    assign hi = {out_hi_3, out_hi_2, out_hi_1, out_hi_0};
    assign lo = {out_lo_3, out_lo_2, out_lo_1, out_lo_0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        control = 1'b0;
        in_v    = 4'b1010;
        #3;
        checks++;
        if ({hi, lo, engaged, busy} !== {4'b0000, 4'b1010, 2'b00}) begin
            errors++;
            $display("FAIL reset_during: hi=%b lo=%b eng=%b busy=%b want 0000 1010 0 0",
                     hi, lo, engaged, busy);
        end
        #9;
        checks++;
        if ({hi, lo, engaged, busy} !== {4'b0000, 4'b1010, 2'b00}) begin
            errors++;
            $display("FAIL reset_clocked: hi=%b lo=%b eng=%b busy=%b want 0000 1010 0 0",
                     hi, lo, engaged, busy);
        end
        #10;
        rst_n = 1'b1;
        cyc();
        checks++;
        if ({hi, lo, engaged, busy} !== {4'b0000, 4'b1010, 2'b00}) begin
            errors++;
            $display("FAIL reset_after: hi=%b lo=%b eng=%b busy=%b want 0000 1010 0 0",
                     hi, lo, engaged, busy);
        end
    endtask

    task automatic test_engage();
        in_v    = 4'b0110;
        control = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if ({hi, lo, engaged, busy} !== {4'b0000, 4'b0000, 2'b01}) begin
                errors++;
                $display("FAIL pulling[%0d]: hi=%b lo=%b eng=%b busy=%b want 0000 0000 0 1",
                         i, hi, lo, engaged, busy);
            end
        end
        cyc();
        checks++;
        if ({hi, lo, engaged, busy} !== {4'b0110, 4'b0000, 2'b10}) begin
            errors++;
            $display("FAIL engaged: hi=%b lo=%b eng=%b busy=%b want 0110 0000 1 0",
                     hi, lo, engaged, busy);
        end
        in_v = 4'b0010;
        #1;
        checks++;
        if (hi !== 4'b0010 || lo !== 4'b0000) begin
            errors++;
            $display("FAIL in2_toggle: hi=%b lo=%b want 0010 0000", hi, lo);
        end
        in_v = 4'b0110;
        #1;
        checks++;
        if (hi !== 4'b0110) begin
            errors++;
            $display("FAIL in2_restore: hi=%b want 0110", hi);
        end
    endtask

    task automatic test_release();
        control = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if ({hi, lo, engaged, busy} !== {4'b0000, 4'b0000, 2'b01}) begin
                errors++;
                $display("FAIL dropping[%0d]: hi=%b lo=%b eng=%b busy=%b want 0000 0000 0 1",
                         i, hi, lo, engaged, busy);
            end
        end
        cyc();
        checks++;
        if ({hi, lo, engaged, busy} !== {4'b0000, 4'b0110, 2'b00}) begin
            errors++;
            $display("FAIL released: hi=%b lo=%b eng=%b busy=%b want 0000 0110 0 0",
                     hi, lo, engaged, busy);
        end
    endtask

    task automatic test_glitch();
        in_v    = 4'b1111;
        control = 1'b1;
        cyc();
        control = 1'b0;
        checks++;
        if (hi !== 4'b0000 || lo !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_pull: hi=%b lo=%b busy=%b want 0000 0000 1",
                     hi, lo, busy);
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (hi !== 4'b0000 || lo !== 4'b0000 || busy !== 1'b1) begin
                errors++;
                $display("FAIL glitch_drop[%0d]: hi=%b lo=%b busy=%b want 0000 0000 1",
                         i, hi, lo, busy);
            end
        end
        cyc();
        checks++;
        if ({hi, lo, engaged, busy} !== {4'b0000, 4'b1111, 2'b00}) begin
            errors++;
            $display("FAIL glitch_end: hi=%b lo=%b eng=%b busy=%b want 0000 1111 0 0",
                     hi, lo, engaged, busy);
        end
    endtask

    task automatic test_abort();
        in_v    = 4'b1001;
        control = 1'b1;
        cyc();
        cyc();
        control = 1'b0;
        cyc();
        checks++;
        if (busy !== 1'b1 || hi !== 4'b0000 || lo !== 4'b0000) begin
            errors++;
            $display("FAIL abort_drop: hi=%b lo=%b busy=%b want 0000 0000 1",
                     hi, lo, busy);
        end
        control = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (busy !== 1'b1 || engaged !== 1'b0 || hi !== 4'b0000) begin
                errors++;
                $display("FAIL repull[%0d]: hi=%b eng=%b busy=%b want 0000 0 1",
                         i, hi, engaged, busy);
            end
        end
        cyc();
        checks++;
        if ({hi, lo, engaged, busy} !== {4'b1001, 4'b0000, 2'b10}) begin
            errors++;
            $display("FAIL repull_eng: hi=%b lo=%b eng=%b busy=%b want 1001 0000 1 0",
                     hi, lo, engaged, busy);
        end
        control = 1'b0;
        repeat (3) cyc();
        checks++;
        if ({lo, busy} !== {4'b1001, 1'b0}) begin
            errors++;
            $display("FAIL abort_rel: lo=%b busy=%b want 1001 0", lo, busy);
        end
    endtask

`ifdef RELAY_CONTACT_COUNT_EN
    task automatic full_engage();
        control = 1'b1;
        repeat (4) cyc();
        control = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic test_count();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        cyc();
        checks++;
        if (engage_count !== 16'd0) begin
            errors++;
            $display("FAIL cnt_reset: got=%h want 0000", engage_count);
        end
        repeat (5) full_engage();
        checks++;
        if (engage_count !== 16'd5) begin
            errors++;
            $display("FAIL cnt_five: got=%h want 0005", engage_count);
        end
        control = 1'b1;
        repeat (2) cyc();
        control = 1'b0;
        repeat (3) cyc();
        checks++;
        if (engage_count !== 16'd5) begin
            errors++;
            $display("FAIL cnt_abort: got=%h want 0005", engage_count);
        end
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        full_engage();
        checks++;
        if (engage_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_top: got=%h want ffff", engage_count);
        end
        full_engage();
        checks++;
        if (engage_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_sat: got=%h want ffff", engage_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_engage();
        test_release();
        test_glitch();
        test_abort();
`ifdef RELAY_CONTACT_COUNT_EN
        test_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
